// File: rtl/qspi_flash_responder.sv
// QSPI flash responder: quad read (0xEB) and quad program (0x32)
// against a small byte memory, driven from a sampled serial bus.
module qspi_flash_responder #(
  parameter int MEM_DEPTH    = 256,
  parameter int DUMMY_CYCLES = 4
) (
  input  logic       h_clk,
  input  logic       h_rst,
  input  logic       cs_n,
  input  logic       sclk,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  output logic [3:0] io_oe,
  output logic       busy,
  output logic       cmd_err
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [7:0] OP_READ = 8'hEB;
  localparam logic [7:0] OP_PROG = 8'h32;

  localparam logic [3:0] DUMMY_LAST =
    4'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RD_DATA,
    S_WR_DATA,
    S_IGNORE
  } state_t;

  state_t         state_q;
  logic           sclk_q;
  logic [3:0]     cnt_q;
  logic [7:0]     cmd_q;
  logic [AW-1:0]  addr_q;
  logic           rd_q;
  logic           nib_hi_q;
  logic [3:0]     hi_q;
  logic [3:0]     io_out_q;
  logic [3:0]     io_oe_q;
  logic           busy_q;
  logic           err_q;

  logic [7:0]     mem_q [MEM_DEPTH];

  logic           rise;
  logic           fall;
  logic [7:0]     cmd_d;
  logic [AW-1:0]  addr_d;
  logic [AW-1:0]  addr_inc_d;
  logic [7:0]     rd_byte;
  logic [3:0]     rd_nib;
  logic           wr_en;

  assign rise = sclk & ~sclk_q;
  assign fall = ~sclk & sclk_q;

  // Opcode arrives on io0, address nibbles on io3..io0;
  // only the low AW address bits survive the shift.
  assign cmd_d  = 8'({cmd_q, io_in[0]});
  assign addr_d = AW'({addr_q, io_in});

  assign addr_inc_d = addr_q + 1'b1;

  assign rd_byte = mem_q[addr_q];
  assign rd_nib  = nib_hi_q ? rd_byte[7:4]
                            : rd_byte[3:0];

  // A deasserted cs_n or reset blocks the write even
  // when it coincides with the second nibble's rise.
  assign wr_en = ~h_rst & ~cs_n & rise
               & (state_q == S_WR_DATA)
               & ~nib_hi_q;

  // Byte store: written on the low nibble, never reset.
  always_ff @(posedge h_clk) begin
    if (wr_en) begin
      mem_q[addr_q] <= {hi_q, io_in};
    end
  end

  // Transaction FSM with registered bus outputs.
  always_ff @(posedge h_clk) begin
    if (h_rst) begin
      state_q  <= S_IDLE;
      sclk_q   <= 1'b0;
      cnt_q    <= '0;
      cmd_q    <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      nib_hi_q <= 1'b0;
      hi_q     <= '0;
      io_out_q <= '0;
      io_oe_q  <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sclk_q <= sclk;
      err_q  <= 1'b0;
      if (cs_n) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        io_out_q <= '0;
        io_oe_q  <= '0;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            state_q <= S_CMD;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
          S_CMD: begin
            if (rise) begin
              cmd_q <= cmd_d;
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == 4'd7) begin
                cnt_q <= '0;
                if (cmd_d == OP_READ) begin
                  state_q <= S_ADDR;
                  rd_q    <= 1'b1;
                end else if (cmd_d == OP_PROG) begin
                  state_q <= S_ADDR;
                  rd_q    <= 1'b0;
                end else begin
                  state_q <= S_IGNORE;
                  err_q   <= 1'b1;
                end
              end
            end
          end
          S_ADDR: begin
            if (rise) begin
              addr_q <= addr_d;
              cnt_q  <= cnt_q + 1'b1;
              if (cnt_q == 4'd5) begin
                cnt_q    <= '0;
                nib_hi_q <= 1'b1;
                state_q  <= rd_q ? S_DUMMY
                                 : S_WR_DATA;
              end
            end
          end
          S_DUMMY: begin
            if (rise) begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == DUMMY_LAST) begin
                cnt_q    <= '0;
                nib_hi_q <= 1'b1;
                state_q  <= S_RD_DATA;
              end
            end
          end
          S_RD_DATA: begin
            if (fall) begin
              io_out_q <= rd_nib;
              io_oe_q  <= 4'hF;
              nib_hi_q <= ~nib_hi_q;
              if (!nib_hi_q) begin
                addr_q <= addr_inc_d;
              end
            end
          end
          S_WR_DATA: begin
            if (rise) begin
              if (nib_hi_q) begin
                hi_q     <= io_in;
                nib_hi_q <= 1'b0;
              end else begin
                nib_hi_q <= 1'b1;
                addr_q   <= addr_inc_d;
              end
            end
          end
          S_IGNORE: begin
            io_out_q <= '0;
            io_oe_q  <= '0;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign io_out  = io_out_q;
  assign io_oe   = io_oe_q;
  assign busy    = busy_q;
  assign cmd_err = err_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: program, read,
// wrap, bad opcode, abort and mid-read reset.
module tb_qspi_flash_responder;

  logic       h_clk;
  logic       h_rst;
  logic       cs_n;
  logic       sclk;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic [3:0] io_oe;
  logic       busy;
  logic       cmd_err;

  int n_chk;
  int n_err;
  int err_cyc;
  int oe_cyc;

  qspi_flash_responder #(
    .MEM_DEPTH   (256),
    .DUMMY_CYCLES(4)
  ) dut (
    .h_clk  (h_clk),
    .h_rst  (h_rst),
    .cs_n   (cs_n),
    .sclk   (sclk),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oe  (io_oe),
    .busy   (busy),
    .cmd_err(cmd_err)
  );

  initial h_clk = 1'b0;
  always #5 h_clk = ~h_clk;

  initial begin
    err_cyc = 0;
    oe_cyc  = 0;
  end

  always @(negedge h_clk) begin
    if (cmd_err === 1'b1) err_cyc++;
    if (io_oe !== 4'h0) oe_cyc++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic clk_bit(input logic [3:0] v);
    @(negedge h_clk);
    io_in = v;
    sclk  = 1'b1;
    repeat (3) @(negedge h_clk);
    sclk = 1'b0;
    repeat (3) @(negedge h_clk);
  endtask

  task automatic cs_start();
    @(negedge h_clk);
    cs_n = 1'b0;
    repeat (3) @(negedge h_clk);
  endtask

  task automatic cs_end();
    @(negedge h_clk);
    cs_n  = 1'b1;
    io_in = 4'h0;
    repeat (3) @(negedge h_clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--)
      clk_bit({3'b000, c[i]});
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--)
      clk_bit(a[4*i +: 4]);
  endtask

  task automatic do_prog(input logic [23:0] a,
                         input logic [15:0] d,
                         input int n);
    cs_start();
    send_cmd(8'h32);
    send_addr(a);
    for (int i = 0; i < n; i++)
      clk_bit(d[15-4*i -: 4]);
    cs_end();
  endtask

  task automatic do_read(input string tag,
                         input logic [23:0] a,
                         input logic [15:0] e,
                         input int n);
    cs_start();
    send_cmd(8'hEB);
    send_addr(a);
    for (int i = 0; i < 4; i++)
      clk_bit(4'h0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) clk_bit(4'h0);
      chk({tag, "_nib"}, 32'(io_out),
          32'(e[15-4*i -: 4]));
      chk({tag, "_oe"}, 32'(io_oe), 32'hF);
    end
    cs_end();
  endtask

  int base_oe;
  int base_err;

  initial begin
    n_chk = 0;
    n_err = 0;
    h_rst = 1'b1;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    io_in = 4'h0;
    repeat (3) @(negedge h_clk);
    chk("rst_oe",   32'(io_oe),   32'h0);
    chk("rst_out",  32'(io_out),  32'h0);
    chk("rst_busy", 32'(busy),    32'h0);
    chk("rst_err",  32'(cmd_err), 32'h0);
    h_rst = 1'b0;
    repeat (2) @(negedge h_clk);

    // program A5 3C at 0x10, bus never driven
    base_oe = oe_cyc;
    cs_start();
    send_cmd(8'h32);
    chk("prog_busy", 32'(busy), 32'h1);
    send_addr(24'h000010);
    clk_bit(4'hA);
    clk_bit(4'h5);
    clk_bit(4'h3);
    clk_bit(4'hC);
    cs_end();
    chk("prog_oe", 32'(oe_cyc - base_oe), 32'h0);

    do_read("rd10", 24'h000010, 16'hA53C, 4);
    chk("end_oe",   32'(io_oe), 32'h0);
    chk("end_busy", 32'(busy),  32'h0);

    // wrap from 0xFF to 0x00
    do_prog(24'h0000FF, 16'h1122, 4);
    do_read("rdFF", 24'h0000FF, 16'h1122, 4);
    do_read("rd00", 24'h000000, 16'h2200, 2);

    // unsupported opcode
    base_oe  = oe_cyc;
    base_err = err_cyc;
    cs_start();
    send_cmd(8'h9F);
    chk("bad_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 6; i++)
      clk_bit(4'hF);
    cs_end();
    chk("bad_err", 32'(err_cyc - base_err), 32'h1);
    chk("bad_oe",  32'(oe_cyc - base_oe),   32'h0);
    do_read("rd_bad", 24'h000010, 16'hA53C, 4);

    // abort a program after one nibble
    do_prog(24'h000020, 16'h5A00, 2);
    do_prog(24'h000020, 16'h7000, 1);
    do_read("rd20", 24'h000020, 16'h5A00, 2);

    // reset in the middle of a read
    cs_start();
    send_cmd(8'hEB);
    send_addr(24'h000010);
    for (int i = 0; i < 4; i++)
      clk_bit(4'h0);
    chk("mid_nib0", 32'(io_out), 32'hA);
    clk_bit(4'h0);
    chk("mid_nib1", 32'(io_out), 32'h5);
    @(negedge h_clk);
    h_rst = 1'b1;
    @(negedge h_clk);
    h_rst = 1'b0;
    chk("mid_rst_oe",   32'(io_oe), 32'h0);
    chk("mid_rst_busy", 32'(busy),  32'h0);
    cs_end();
    do_read("rd_rst", 24'h000010, 16'hA53C, 4);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
